tagged_fifo_bank: RTL
=====================

# tagged_fifo_bank

Multi-flux token buffer that sits directly upstream of the HEVC delayer stage and feeds its read side. It accepts tagged tokens from a single producer and steers each token into one of FLUX independent FIFO lanes according to its tag. It exposes per-lane `empty`/`read` handshakes and a shared `dout` to the consumer. Tokens within a lane stay in order; tokens in different lanes are independent.

## Interface
- `DATA_WIDTH`, 8, payload bits per token
- `FLUX`, 2, number of lanes (≥2)
- `DEPTH`, 4, entries per lane; power of 2, ≥2
- Derived: `TAG_WIDTH = $clog2(FLUX)`, `WIDTH = DATA_WIDTH + TAG_WIDTH`

Ports:
- `clk`  in  1  single clock; all state updates on the rising edge
- `rst`  in  1  asynchronous, active-low reset
- `write`  in  1  producer write strobe
- `din`  in  WIDTH  token; tag field is `din[WIDTH-1:DATA_WIDTH]`
- `full`  out  1  write side may not accept a token
- `read`  in  FLUX  consumer pop request, one bit per lane
- `empty`  out  FLUX  per-lane empty flag
- `dout`  out  WIDTH  head token of the selected lane, stored unmodified with its tag

## Operation
- **Storage:**
  - Each lane is a circular buffer of DEPTH×WIDTH entries.
  - Each lane has a write pointer, a read pointer (both `$clog2(DEPTH)` bits, wrapping modulo DEPTH) and an occupancy count (`$clog2(DEPTH+1)` bits, range 0..DEPTH).
- **Write:**
  - The token is accepted when `write==1 & full==0`.
  - It is stored at lane[tag].wptr; that lane's wptr and count then increment.
  - A write while `full==1` is dropped and leaves all state unchanged.
  - A tag ≥ FLUX (non-power-of-2 FLUX) is dropped and flagged by a simulation assertion.
- **full:**
  - `full = OR over lanes of (count==DEPTH)`.
  - It is derived from registers only; there is no combinational path from `din`.
- **empty[i]** is `(count_i==0)`, derived from registers only.
- **Read:**
  - `read[i]==1 & empty[i]==0` pops lane i: its rptr increments and its count decrements.
  - `read[i]` on an empty lane is ignored.
  - `read` must be one-hot or zero. If several bits are set, only the highest index is serviced and an assertion fires.
- **dout selection (combinational):**
  - If any `read` bit is set, `dout` is the head of that lane.
  - Otherwise `dout` is the head of the highest-index non-empty lane. This matches the consumer's priority and lets it sample `dout` in the same cycle it raises `read`.
  - If all lanes are empty, `dout = '0`.
- **Simultaneous write and read, same lane, non-empty:** both take effect; the count is unchanged.
- **Simultaneous write and read, same lane, empty:** the write is stored and the read is ignored. There is no bypass path.
- **Simultaneous write and read, different lanes:** the operations are independent.
- **Reset (asynchronous, any time, including mid-stream):**
  - All pointers and counts are cleared.
  - Outputs go to `empty='1`, `full=0`, `dout='0`.
  - Memory contents are not reset.

## Timing
- A token written at edge N is visible at `dout` and clears `empty[tag]` after edge N; its minimum write-to-read latency is 1 cycle.
- A pop at edge N updates the head, `empty` and `full` after edge N.
- `full` reflects the state after the last edge, so it drops the cycle after a pop frees the full lane.
- Throughput is 1 write and 1 read per cycle sustained.
- Combinational paths `read`→`dout` exist. There are no paths `din`→`full`, `read`→`empty` or `write`→`full`.

## Structure
- Package `fifo_pkg` holds:
  - a `tag_width(flux)` function;
  - a `lane_state_t` struct containing wptr, rptr and count;
  - the `WIDTH` computation helper.
- Sub-module `fifo_lane` implements one circular buffer and is instantiated FLUX times via generate. Its ports:
  - in: `push`, `pop`, `din`
  - out: `head`, `count`, `empty`, `is_full`
- The top level contains the tag decode, the `full` OR-reduction and the `dout` priority mux.

## Test plan
- **Reset:** assert `rst=0` mid-stream with lanes partly filled → next cycle `empty=2'b11`, `full=0`, `dout=0`; prior tokens are never delivered.
- **Steering:** with FLUX=2 and DEPTH=4, write tag0/0x11, then tag1/0x22 → `empty=2'b00`; `dout=tag1/0x22` with no read; `read=2'b01` → `dout=tag0/0x11` and lane 0 pops.
- **Fill:** write 4 tokens with tag1 → `full=1`; a 5th write is dropped; one pop of lane 1 → `full=0` the next cycle.
- **Concurrent push/pop:** hold lane 0 at count 2 and write+read lane 0 every cycle for 10 cycles → count stays 2 and FIFO order is preserved.
- **Empty write+read:** with lane 1 empty, `write` tag1/0x5A together with `read=2'b10` → the token is stored; `empty[1]` deasserts next cycle; a later pop returns 0x5A.
- **Wrap:** run 3×DEPTH interleaved tokens through both lanes → pointers wrap; per-lane output order matches a scoreboard model.

Source files
------------

// File: rtl/fifo_pkg.sv
// Shared definitions for the tagged FIFO bank.
//   tag_width()   : number of tag bits needed to address FLUX lanes
//   token_width() : stored token width (payload plus tag)
//   lane_state_t  : per-lane write pointer, read pointer and occupancy
// The lane state fields use a fixed width, so a lane may be at most
// 2**STATE_W - 1 entries deep. Each lane wraps its pointers modulo its
// own depth inside these fields.
package fifo_pkg;

    localparam int STATE_W = 8;

    typedef struct packed {
        logic [STATE_W-1:0] wptr;
        logic [STATE_W-1:0] rptr;
        logic [STATE_W-1:0] count;
    } lane_state_t;

    function automatic int tag_width(input int flux);
        return (flux > 1) ? $clog2(flux) : 1;
    endfunction

    function automatic int token_width(input int data_width, input int flux);
        return data_width + tag_width(flux);
    endfunction

endpackage

// File: rtl/fifo_lane.sv
// One circular-buffer lane of the tagged FIFO bank.
// Ports:
//   clk, rst     : clock, asynchronous active-low reset
//   push, pop    : store din at the tail / drop the head
//   din          : token to store
//   head         : token at the read pointer (stale when empty)
//   count        : occupancy, 0..DEPTH
//   empty        : count == 0
//   is_full      : count == DEPTH
// A push while full and a pop while empty are ignored. Memory is not reset.
module fifo_lane
    import fifo_pkg::*;
#(
    parameter int WIDTH = 9,
    parameter int DEPTH = 4
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         push,
    input  logic                         pop,
    input  logic [WIDTH-1:0]             din,
    output logic [WIDTH-1:0]             head,
    output logic [$clog2(DEPTH+1)-1:0]   count,
    output logic                         empty,
    output logic                         is_full
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam logic [STATE_W-1:0] PTR_MASK = STATE_W'(DEPTH - 1);
    localparam logic [STATE_W-1:0] DEPTH_V  = STATE_W'(DEPTH);
    localparam logic [STATE_W-1:0] ONE      = STATE_W'(1);

    logic [WIDTH-1:0] mem [DEPTH];
    lane_state_t      st;
    logic             do_push;
    logic             do_pop;

    assign do_push = push & ~is_full;
    assign do_pop  = pop & ~empty;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            st <= '0;
        end else begin
            // DEPTH is a power of two, so masking implements the wrap.
            if (do_push) st.wptr <= (st.wptr + ONE) & PTR_MASK;
            if (do_pop)  st.rptr <= (st.rptr + ONE) & PTR_MASK;
            case ({do_push, do_pop})
                2'b10:   st.count <= st.count + ONE;
                2'b01:   st.count <= st.count - ONE;
                default: st.count <= st.count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[st.wptr[PTR_W-1:0]] <= din;
    end

    assign head    = mem[st.rptr[PTR_W-1:0]];
    assign count   = st.count[CNT_W-1:0];
    assign empty   = (st.count == '0);
    assign is_full = (st.count == DEPTH_V);

endmodule

// File: rtl/tagged_fifo_bank.sv
// Tagged token buffer: steers each written token into one of FLUX FIFO
// lanes by its tag and serves the consumer through per-lane empty/read.
// Ports:
//   clk, rst : clock, asynchronous active-low reset
//   write    : producer strobe; din[WIDTH-1:DATA_WIDTH] is the tag
//   din      : token, stored unmodified with its tag
//   full     : high when any lane is full; write side then accepts nothing
//   read     : per-lane pop request, one-hot or zero
//   empty    : per-lane empty flag
//   dout     : head of the lane named by read, else of the highest
//              non-empty lane, else zero
// Handshake: a token transfers on a rising edge when write=1 and full=0;
// lane i pops on a rising edge when read[i]=1 and empty[i]=0. full and
// empty come from registers only; dout depends combinationally on read so
// the consumer can sample it in the cycle it raises read.
module tagged_fifo_bank
    import fifo_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int FLUX       = 2,
    parameter int DEPTH      = 4
) (
    input  logic                                          clk,
    input  logic                                          rst,
    input  logic                                          write,
    input  logic [token_width(DATA_WIDTH, FLUX)-1:0]      din,
    output logic                                          full,
    input  logic [FLUX-1:0]                               read,
    output logic [FLUX-1:0]                               empty,
    output logic [token_width(DATA_WIDTH, FLUX)-1:0]      dout
);

    localparam int TAG_WIDTH = tag_width(FLUX);
    localparam int WIDTH     = token_width(DATA_WIDTH, FLUX);
    localparam int CNT_W     = $clog2(DEPTH + 1);

    logic [TAG_WIDTH-1:0] tag;
    logic                 tag_ok;
    logic                 accept;
    logic                 any_read;
    int                   sel;
    logic [FLUX-1:0]      push;
    logic [FLUX-1:0]      pop;
    logic [FLUX-1:0]      lane_full;
    logic [WIDTH-1:0]     lane_head  [FLUX];
    logic [CNT_W-1:0]     lane_count [FLUX];

    assign tag      = din[WIDTH-1:DATA_WIDTH];
    // Tags at or above FLUX can only occur when FLUX is not a power of two.
    assign tag_ok   = (32'(tag) < FLUX);
    assign accept   = write & ~full & tag_ok;
    assign full     = |lane_full;
    assign any_read = |read;

    always_comb begin
        push = '0;
        pop  = '0;
        dout = '0;
        sel  = 0;
        // Highest set read bit wins if the consumer breaks the one-hot rule.
        for (int i = 0; i < FLUX; i++) begin
            if (read[i]) sel = i;
        end
        for (int i = 0; i < FLUX; i++) begin
            push[i] = accept && (32'(tag) == i);
            pop[i]  = any_read && (sel == i);
            // Idle: the last non-empty lane in index order is the highest.
            if (any_read ? ((sel == i) && !empty[i]) : !empty[i])
                dout = lane_head[i];
        end
    end

    for (genvar g = 0; g < FLUX; g++) begin : g_lane
        fifo_lane #(
            .WIDTH (WIDTH),
            .DEPTH (DEPTH)
        ) u_lane (
            .clk     (clk),
            .rst     (rst),
            .push    (push[g]),
            .pop     (pop[g]),
            .din     (din),
            .head    (lane_head[g]),
            .count   (lane_count[g]),
            .empty   (empty[g]),
            .is_full (lane_full[g])
        );

        always_ff @(posedge clk) begin
            if (rst) begin
                assert (32'(lane_count[g]) <= DEPTH)
                    else $error("lane %0d occupancy out of range", g);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            assert ($onehot0(read))
                else $error("read is not one-hot: %b", read);
            if (write && !full) begin
                assert (tag_ok)
                    else $error("write with tag %0d beyond lane count", tag);
            end
        end
    end

endmodule
